// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the cache line-refill port arbiter.
// Widths, state encoding, grant ids and the pending-request bundle.
package mem_port_arbiter_pkg;

    localparam int ADDR_W        = 32;
    localparam int LINE_W        = 128;
    localparam int LINE_OFF_BITS = 4;

    localparam logic [1:0] ARB_IDLE   = 2'd0;
    localparam logic [1:0] ARB_I_BUSY = 2'd1;
    localparam logic [1:0] ARB_D_BUSY = 2'd2;

    localparam logic REQ_I = 1'b0;
    localparam logic REQ_D = 1'b1;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] addr;
        logic              we;
        logic [LINE_W-1:0] wdata;
    } slot_t;

    function automatic logic [ADDR_W-1:0] line_addr(
        input logic [ADDR_W-1:0] a
    );
        return {a[ADDR_W-1:LINE_OFF_BITS], {LINE_OFF_BITS{1'b0}}};
    endfunction

endpackage

// File: rtl/mem_port_arbiter_slot.sv
// One-deep pending request capture for a single requester.
// A new pulse overwrites the entry and takes priority over a clear.
module arb_req_slot
    import mem_port_arbiter_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              clear,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic              ld_we,
    input  logic [LINE_W-1:0] ld_wdata,
    output slot_t             slot
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            slot <= '0;
        end else if (load) begin
            slot.valid <= 1'b1;
            slot.addr  <= ld_addr;
            slot.we    <= ld_we;
            slot.wdata <= ld_wdata;
        end else if (clear) begin
            slot.valid <= 1'b0;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one line-refill memory port between
// the Icache and Dcache, with stale Icache response suppression.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] Icache_addr_i,
    input  logic              Icache_valid_req_i,
    output logic              bc_Icache_ready_o,
    output logic [LINE_W-1:0] bc_Icache_data_o,
    input  logic [ADDR_W-1:0] Dcache_addr_i,
    input  logic              Dcache_valid_req_i,
    input  logic              Dcache_we_i,
    input  logic [LINE_W-1:0] Dcache_wdata_i,
    output logic              bc_Dcache_ready_o,
    output logic [LINE_W-1:0] bc_Dcache_data_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [LINE_W-1:0] mem_wdata_o,
    input  logic              mem_ack_i,
    input  logic [LINE_W-1:0] mem_rdata_i
);

    logic [1:0] state;
    logic       last_grant;
    logic       i_stale;

    slot_t i_slot, d_slot;
    slot_t i_cand, d_cand, sel;
    logic  idle, grant_i, grant_d;
    logic  ack_i, ack_d;

    // Current-cycle pulses bypass the slot so a lone request costs no cycle.
    always_comb begin
        i_cand = i_slot;
        d_cand = d_slot;
        if (Icache_valid_req_i) begin
            i_cand.valid = 1'b1;
            i_cand.addr  = Icache_addr_i;
            i_cand.we    = 1'b0;
            i_cand.wdata = '0;
        end
        if (Dcache_valid_req_i) begin
            d_cand.valid = 1'b1;
            d_cand.addr  = Dcache_addr_i;
            d_cand.we    = Dcache_we_i;
            d_cand.wdata = Dcache_wdata_i;
        end
        idle    = (state == ARB_IDLE);
        grant_i = idle && i_cand.valid &&
                  (!d_cand.valid || last_grant == REQ_D);
        grant_d = idle && d_cand.valid && !grant_i;
        sel     = grant_d ? d_cand : i_cand;
        ack_i   = (state == ARB_I_BUSY) && mem_ack_i;
        ack_d   = (state == ARB_D_BUSY) && mem_ack_i;
    end

    arb_req_slot u_i_slot (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (Icache_valid_req_i && !grant_i),
        .clear    (grant_i),
        .ld_addr  (Icache_addr_i),
        .ld_we    (1'b0),
        .ld_wdata ('0),
        .slot     (i_slot)
    );

    arb_req_slot u_d_slot (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (Dcache_valid_req_i && !grant_d),
        .clear    (grant_d),
        .ld_addr  (Dcache_addr_i),
        .ld_we    (Dcache_we_i),
        .ld_wdata (Dcache_wdata_i),
        .slot     (d_slot)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state             <= ARB_IDLE;
            last_grant        <= REQ_D;
            i_stale           <= 1'b0;
            mem_req_o         <= 1'b0;
            mem_we_o          <= 1'b0;
            mem_addr_o        <= '0;
            mem_wdata_o       <= '0;
            bc_Icache_ready_o <= 1'b0;
            bc_Icache_data_o  <= '0;
            bc_Dcache_ready_o <= 1'b0;
            bc_Dcache_data_o  <= '0;
        end else begin
            bc_Icache_ready_o <= 1'b0;
            bc_Dcache_ready_o <= 1'b0;
            unique case (1'b1)
                (grant_i || grant_d): begin
                    mem_req_o   <= 1'b1;
                    mem_addr_o  <= line_addr(sel.addr);
                    mem_we_o    <= sel.we;
                    mem_wdata_o <= sel.wdata;
                    last_grant  <= grant_d ? REQ_D : REQ_I;
                    state       <= grant_d ? ARB_D_BUSY : ARB_I_BUSY;
                end
                ack_i: begin
                    mem_req_o <= 1'b0;
                    state     <= ARB_IDLE;
                    i_stale   <= 1'b0;
                    // A re-issued fetch makes this line useless to the core.
                    if (!(i_stale || Icache_valid_req_i)) begin
                        bc_Icache_ready_o <= 1'b1;
                        bc_Icache_data_o  <= mem_rdata_i;
                    end
                end
                ack_d: begin
                    mem_req_o         <= 1'b0;
                    state             <= ARB_IDLE;
                    bc_Dcache_ready_o <= 1'b1;
                    bc_Dcache_data_o  <= mem_we_o ? '0 : mem_rdata_i;
                end
                default: ;
            endcase
            if (state == ARB_I_BUSY && Icache_valid_req_i && !mem_ack_i)
                i_stale <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a response scoreboard.
// Expected ready data is queued when the memory ack is driven.
module tb_mem_port_arbiter;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [31:0]  Icache_addr_i;
    logic         Icache_valid_req_i;
    logic         bc_Icache_ready_o;
    logic [127:0] bc_Icache_data_o;
    logic [31:0]  Dcache_addr_i;
    logic         Dcache_valid_req_i;
    logic         Dcache_we_i;
    logic [127:0] Dcache_wdata_i;
    logic         bc_Dcache_ready_o;
    logic [127:0] bc_Dcache_data_o;
    logic         mem_req_o;
    logic         mem_we_o;
    logic [31:0]  mem_addr_o;
    logic [127:0] mem_wdata_o;
    logic         mem_ack_i;
    logic [127:0] mem_rdata_i;

    int checks = 0;
    int errors = 0;
    logic [127:0] iq[$];
    logic [127:0] dq[$];

    mem_port_arbiter dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .Icache_addr_i      (Icache_addr_i),
        .Icache_valid_req_i (Icache_valid_req_i),
        .bc_Icache_ready_o  (bc_Icache_ready_o),
        .bc_Icache_data_o   (bc_Icache_data_o),
        .Dcache_addr_i      (Dcache_addr_i),
        .Dcache_valid_req_i (Dcache_valid_req_i),
        .Dcache_we_i        (Dcache_we_i),
        .Dcache_wdata_i     (Dcache_wdata_i),
        .bc_Dcache_ready_o  (bc_Dcache_ready_o),
        .bc_Dcache_data_o   (bc_Dcache_data_o),
        .mem_req_o          (mem_req_o),
        .mem_we_o           (mem_we_o),
        .mem_addr_o         (mem_addr_o),
        .mem_wdata_o        (mem_wdata_o),
        .mem_ack_i          (mem_ack_i),
        .mem_rdata_i        (mem_rdata_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every ready pulse must match the oldest queued line.
    always @(negedge clk) begin
        if (bc_Icache_ready_o) begin
            chk("i_ready_expected", 128'(iq.size() != 0), 128'd1);
            if (iq.size() != 0)
                chk("i_data", bc_Icache_data_o, iq.pop_front());
        end
        if (bc_Dcache_ready_o) begin
            chk("d_ready_expected", 128'(dq.size() != 0), 128'd1);
            if (dq.size() != 0)
                chk("d_data", bc_Dcache_data_o, dq.pop_front());
        end
    end

    task automatic do_reset();
        rst_n              = 1'b0;
        Icache_valid_req_i = 1'b0;
        Dcache_valid_req_i = 1'b0;
        mem_ack_i          = 1'b0;
        mem_rdata_i        = '0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Expects mem_req_o already high; acks in the n-th cycle of the request.
    task automatic serve(input bit is_d, input logic [31:0] a,
                         input logic we, input logic [127:0] wd,
                         input logic [127:0] rd, input int n);
        for (int i = 0; i < n; i++) begin
            chk("req_hold", 128'(mem_req_o), 128'd1);
            chk("mem_addr", 128'(mem_addr_o), 128'(a));
            chk("mem_we", 128'(mem_we_o), 128'(we));
            if (we) chk("mem_wdata", mem_wdata_o, wd);
            if (i == n - 1) begin
                mem_ack_i   = 1'b1;
                mem_rdata_i = rd;
                if (is_d) dq.push_back(we ? 128'd0 : rd);
                else      iq.push_back(rd);
            end
            tick();
        end
        mem_ack_i   = 1'b0;
        mem_rdata_i = '0;
        chk("req_drop", 128'(mem_req_o), 128'd0);
        chk(is_d ? "d_ready" : "i_ready",
            128'(is_d ? bc_Dcache_ready_o : bc_Icache_ready_o), 128'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        Icache_addr_i  = '0;
        Dcache_addr_i  = '0;
        Dcache_we_i    = 1'b0;
        Dcache_wdata_i = '0;
        do_reset();

        chk("rst_req", 128'(mem_req_o), 128'd0);
        chk("rst_we", 128'(mem_we_o), 128'd0);
        chk("rst_addr", 128'(mem_addr_o), 128'd0);
        chk("rst_wdata", mem_wdata_o, 128'd0);
        chk("rst_iready", 128'(bc_Icache_ready_o), 128'd0);
        chk("rst_dready", 128'(bc_Dcache_ready_o), 128'd0);
        chk("rst_idata", bc_Icache_data_o, 128'd0);
        chk("rst_ddata", bc_Dcache_data_o, 128'd0);

        // Single Icache refill, 3-cycle request.
        Icache_addr_i      = 32'h0000_1234;
        Icache_valid_req_i = 1'b1;
        tick();
        Icache_valid_req_i = 1'b0;
        serve(1'b0, 32'h0000_1230, 1'b0, '0, {16{8'hA5}}, 3);
        tick();
        chk("i_ready_one_shot", 128'(bc_Icache_ready_o), 128'd0);
        chk("i_data_hold", bc_Icache_data_o, {16{8'hA5}});

        // Simultaneous I and D after reset: I first, one idle cycle.
        do_reset();
        Icache_addr_i      = 32'h0000_2000;
        Dcache_addr_i      = 32'h0000_3008;
        Dcache_we_i        = 1'b0;
        Icache_valid_req_i = 1'b1;
        Dcache_valid_req_i = 1'b1;
        tick();
        Icache_valid_req_i = 1'b0;
        Dcache_valid_req_i = 1'b0;
        serve(1'b0, 32'h0000_2000, 1'b0, '0, {4{32'h1234_5678}}, 2);
        tick();
        serve(1'b1, 32'h0000_3000, 1'b0, '0, {4{32'h8765_4321}}, 1);
        tick();

        // Dcache writeback, wdata sampled with the pulse.
        Dcache_addr_i      = 32'h8000_0040;
        Dcache_we_i        = 1'b1;
        Dcache_wdata_i     = {32{4'h1}};
        Dcache_valid_req_i = 1'b1;
        tick();
        Dcache_valid_req_i = 1'b0;
        Dcache_we_i        = 1'b0;
        Dcache_wdata_i     = {32{4'hF}};
        serve(1'b1, 32'h8000_0040, 1'b1, {32{4'h1}},
              {4{32'hBEEF_BEEF}}, 4);
        chk("wb_data_zero", bc_Dcache_data_o, 128'd0);
        tick();

        // Stale fetch: re-issued I request hides the first response.
        Icache_addr_i      = 32'h0000_0100;
        Icache_valid_req_i = 1'b1;
        tick();
        Icache_valid_req_i = 1'b0;
        chk("stale_req1", 128'(mem_addr_o), 128'h100);
        Icache_addr_i      = 32'h0000_0200;
        Icache_valid_req_i = 1'b1;
        tick();
        Icache_valid_req_i = 1'b0;
        chk("stale_hold_addr", 128'(mem_addr_o), 128'h100);
        mem_ack_i   = 1'b1;
        mem_rdata_i = {4{32'hDEAD_0100}};
        tick();
        mem_ack_i   = 1'b0;
        mem_rdata_i = '0;
        chk("stale_req_drop", 128'(mem_req_o), 128'd0);
        chk("stale_no_ready", 128'(bc_Icache_ready_o), 128'd0);
        tick();
        serve(1'b0, 32'h0000_0200, 1'b0, '0, {4{32'hC0FE_0200}}, 2);
        tick();

        // Round-robin: both keep re-requesting; grants must alternate.
        do_reset();
        Icache_addr_i      = 32'h0000_4000;
        Dcache_addr_i      = 32'h0000_5000;
        Dcache_we_i        = 1'b0;
        Icache_valid_req_i = 1'b1;
        Dcache_valid_req_i = 1'b1;
        tick();
        Icache_valid_req_i = 1'b0;
        Dcache_valid_req_i = 1'b0;
        for (int k = 0; k < 6; k++) begin
            bit is_d;
            is_d = k[0];
            serve(is_d, is_d ? 32'h0000_5000 : 32'h0000_4000, 1'b0, '0,
                  {4{32'hC0DE_0000 + 32'(k)}}, 1);
            if (k < 5) begin
                if (is_d) Dcache_valid_req_i = 1'b1;
                else      Icache_valid_req_i = 1'b1;
                tick();
                Icache_valid_req_i = 1'b0;
                Dcache_valid_req_i = 1'b0;
            end
        end

        // Reset in D_BUSY abandons the transaction.
        do_reset();
        Dcache_addr_i      = 32'h0000_6000;
        Dcache_we_i        = 1'b1;
        Dcache_wdata_i     = {4{32'h5555_AAAA}};
        Dcache_valid_req_i = 1'b1;
        tick();
        Dcache_valid_req_i = 1'b0;
        Dcache_we_i        = 1'b0;
        chk("mid_req", 128'(mem_req_o), 128'd1);
        rst_n = 1'b0;
        tick();
        chk("mid_rst_req", 128'(mem_req_o), 128'd0);
        chk("mid_rst_we", 128'(mem_we_o), 128'd0);
        chk("mid_rst_addr", 128'(mem_addr_o), 128'd0);
        chk("mid_rst_wdata", mem_wdata_o, 128'd0);
        chk("mid_rst_ddata", bc_Dcache_data_o, 128'd0);
        rst_n       = 1'b1;
        mem_ack_i   = 1'b1;
        mem_rdata_i = {4{32'hFFFF_0000}};
        tick();
        mem_ack_i   = 1'b0;
        chk("late_ack_no_dready", 128'(bc_Dcache_ready_o), 128'd0);
        chk("late_ack_no_req", 128'(mem_req_o), 128'd0);
        tick();
        chk("late_ack_no_dready2", 128'(bc_Dcache_ready_o), 128'd0);
        tick();

        chk("iq_drained", 128'(iq.size()), 128'd0);
        chk("dq_drained", 128'(dq.size()), 128'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
